fc_acc_bank: RTL

Parametrised bank of NUM_CH signed accumulators for the fully connected output stage. Replaces the fixed 10-channel register-accumulator wrapper. Each inference:
- preloads per-channel biases on `start`;
- accumulates NUM_TERMS partial-sum beats under a valid/ready handshake;
- drains the channel results serially on a valid/ready output port;
- reports the argmax class index.

Sits between the FC multiplier array and the classifier/readout logic.

---
 rtl/fc_pkg.sv | 34 +++
 rtl/fc_acc_bank_lane.sv | 40 ++++
 rtl/fc_acc_bank.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the FC accumulator bank: arithmetic modes, FSM states
// and the saturating adder used by the per-channel lanes.
package fc_pkg;

    localparam int ARITH_WRAP = 0;
    localparam int ARITH_SAT  = 1;
    localparam int SAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN
    } state_t;

    // Operands arrive sign-extended to SAT_W bits; the caller keeps the low dw bits.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int dw);
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] mx;
        logic signed [SAT_W:0] mn;
        logic signed [SAT_W:0] one;
        one = {{SAT_W{1'b0}}, 1'b1};
        s   = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
        mx  = (one <<< (dw - 1)) - one;
        mn  = -mx - one;
        if (s > mx)
            s = mx;
        else if (s < mn)
            s = mn;
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/fc_acc_bank_lane.sv
// One signed accumulator channel: load bias, add a partial sum, or hold.
module acc_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = ARITH_WRAP
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_bias,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_acc
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_sum;

    generate
        if (ARITH_TYPE == ARITH_SAT) begin : g_sat
            assign w_sum = DATA_WIDTH'(sat_add(SAT_W'($signed(r_acc)),
                                               SAT_W'($signed(i_data)), DATA_WIDTH));
        end else begin : g_wrap
            assign w_sum = r_acc + i_data;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_acc <= '0;
        else if (i_load)
            r_acc <= i_bias;
        else if (i_add)
            r_acc <= w_sum;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fc_acc_bank.sv
// Bank of NUM_CH signed accumulators: bias preload, NUM_TERMS handshaked
// partial-sum beats, serial drain of the results and argmax class report.
module fc_acc_bank
    import fc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 10,
    parameter  int NUM_TERMS  = 120,
    parameter  int ARITH_TYPE = ARITH_WRAP,
    localparam int IDX_W      = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_bias_in,
    input  logic                         i_in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_in_data,
    output logic                         o_in_ready,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic [IDX_W-1:0]             o_out_idx,
    output logic                         o_out_last,
    output logic [IDX_W-1:0]             o_class_idx,
    output logic                         o_class_valid,
    output logic                         o_busy
);

    localparam int               CNT_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

    state_t r_state, w_next;
    logic   w_load, w_beat, w_take;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_acc;
    logic [DATA_WIDTH-1:0]             w_cur;
    logic                              w_better;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_ch;
    logic [DATA_WIDTH-1:0] r_best;
    logic [IDX_W-1:0]      r_bidx;
    logic [IDX_W-1:0]      r_class_idx;
    logic                  r_class_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        acc_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ARITH_TYPE(ARITH_TYPE)
        ) u_lane (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_load (w_load),
            .i_add  (w_beat),
            .i_bias (i_bias_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_data (i_in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_acc  (w_acc[i])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_beat = 1'b0;
        w_take = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = ACC;
                end
            end
            ACC: begin
                if (i_in_valid) begin
                    w_beat = 1'b1;
                    if (r_cnt == LAST_TERM)
                        w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_out_ready) begin
                    w_take = 1'b1;
                    if (r_ch == LAST_CH)
                        w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_cur    = w_acc[r_ch];
    assign w_better = $signed(w_cur) > $signed(r_best);

    // Strict compare keeps the lower index on ties; channel 0 always seeds the tracker.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_ch          <= '0;
            r_best        <= '0;
            r_bidx        <= '0;
            r_class_idx   <= '0;
            r_class_valid <= 1'b0;
        end else begin
            r_class_valid <= 1'b0;
            if (w_load)
                r_cnt <= '0;
            else if (w_beat)
                r_cnt <= r_cnt + 1'b1;
            if (w_beat && r_cnt == LAST_TERM)
                r_ch <= '0;
            if (w_take) begin
                r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
                if (r_ch == '0 || w_better) begin
                    r_best <= w_cur;
                    r_bidx <= r_ch;
                end
                if (r_ch == LAST_CH) begin
                    r_class_idx   <= w_better ? r_ch : r_bidx;
                    r_class_valid <= 1'b1;
                end
            end
        end
    end

    assign o_in_ready    = (r_state == ACC);
    assign o_out_valid   = (r_state == DRAIN);
    assign o_out_data    = w_cur;
    assign o_out_idx     = r_ch;
    assign o_out_last    = (r_state == DRAIN) && (r_ch == LAST_CH);
    assign o_class_idx   = r_class_idx;
    assign o_class_valid = r_class_valid;
    assign o_busy        = (r_state != IDLE);

endmodule
